// File: rtl/seg_ctrl_pkg.sv
// seg_ctrl_pkg
//   Shared definitions for the seven-segment update arbiter: FSM state
//   encoding, number of bytes per display update and a byte-select helper.
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } seg_state_e;

    localparam int SEG_NUM_BYTES = 4;

    // Byte k of a 32-bit display value (byte 0 = HEX0/HEX1).
    function automatic logic [7:0] seg_byte(input logic [31:0] value, input logic [1:0] k);
        return value[8*k +: 8];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with a registered priority pointer.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     req[1:0]   request vector
//     advance    a grant is being consumed this cycle; move the pointer
//     gnt[1:0]   one-hot grant (combinational from req and pointer)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr_q = 0: requester 0 has priority under contention.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr_q)) gnt = 2'b01;
        else if (req[1])                   gnt = 2'b10;
    end

    // After a win, priority passes to the other requester.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (gnt != 2'b00)) ptr_d = gnt[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/seg_update_arbiter.sv
// seg_update_arbiter
//   Shares the 8-digit seven-segment display between two requesters. A
//   winning 32-bit value is captured into a shadow register, then written as
//   four bytes to ADDRESS..ADDRESS+3 over the shared byte bus. An optional
//   idle gap follows each update.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     req0/data0/ack0    requester 0 handshake (ack is a one-cycle pulse)
//     req1/data1/ack1    requester 1 handshake
//     bus_req, bus_gnt   byte bus ownership request / grant (level)
//     addr, wr, bus_out  byte write address, strobe and data
//     busy               any state other than IDLE
module seg_update_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int ADDRESS           = 0,
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int MIN_GAP           = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0,
    input  logic [31:0]                  data0,
    output logic                         ack0,
    input  logic                         req1,
    input  logic [31:0]                  data1,
    output logic                         ack1,
    output logic                         bus_req,
    input  logic                         bus_gnt,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr,
    output logic                         wr,
    output logic [7:0]                   bus_out,
    output logic                         busy
);

    localparam int AW    = BUS_ADDR_DATA_LEN;
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [1:0]       K_LAST   = 2'(SEG_NUM_BYTES - 1);

    seg_state_e        state_q, state_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [1:0]        k_q, k_d;
    logic              done_q, done_d;      // last byte written; release the bus next cycle
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              bus_req_q, bus_req_d, wr_q, wr_d, busy_q, busy_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [7:0]        bus_out_q, bus_out_d;
    logic [1:0]        arb_gnt;

    // The pointer only moves on an actual IDLE win.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1, req0}),
        .advance (state_q == ST_IDLE),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        k_d       = k_q;
        done_d    = done_q;
        gap_d     = gap_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        bus_req_d = bus_req_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        bus_out_d = bus_out_q;
        case (state_q)
            ST_IDLE: begin
                bus_req_d = 1'b0;
                if (arb_gnt != 2'b00) begin
                    shadow_d  = arb_gnt[0] ? data0 : data1;
                    ack0_d    = arb_gnt[0];
                    ack1_d    = arb_gnt[1];
                    k_d       = 2'd0;
                    done_d    = 1'b0;
                    bus_req_d = 1'b1;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                bus_req_d = 1'b1;
                if (bus_gnt) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (done_q) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b0;
                    gap_d     = '0;
                    state_d   = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
                end else if (bus_gnt) begin
                    // Without grant k holds, so the same byte is re-issued later.
                    wr_d      = 1'b1;
                    addr_d    = AW'(ADDRESS) + AW'(k_q);
                    bus_out_d = seg_byte(shadow_q, k_q);
                    if (k_q == K_LAST) done_d = 1'b1;
                    else               k_d    = k_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            gap_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            bus_req_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            bus_out_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            k_q       <= k_d;
            done_q    <= done_d;
            gap_q     <= gap_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            bus_req_q <= bus_req_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            bus_out_q <= bus_out_d;
            busy_q    <= busy_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign bus_req = bus_req_q;
    assign wr      = wr_q;
    assign addr    = addr_q;
    assign bus_out = bus_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_seg_update_arbiter.sv
module tb_seg_update_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, bus_gnt;
    logic [31:0] data0, data1;
    logic        ack0, ack1, bus_req, wr, busy;
    logic [15:0] addr;
    logic [7:0]  bus_out;

    logic        g_req0, g_req1, g_gnt;
    logic [31:0] g_data0, g_data1;
    logic        g_ack0, g_ack1, g_bus_req, g_wr, g_busy;
    logic [15:0] g_addr;
    logic [7:0]  g_bus_out;

    int npass = 0;
    int ntotal = 0;

    logic [23:0] wq[$];
    logic [23:0] gq[$];
    int g_acks = 0, g_ack_double = 0, g_run = 0, g_min_run = 999;
    bit g_ack_prev = 0, g_seen_hi = 0;

    seg_update_arbiter #(.ADDRESS(16'h0100), .BUS_ADDR_DATA_LEN(16), .MIN_GAP(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .addr(addr), .wr(wr), .bus_out(bus_out), .busy(busy)
    );

    seg_update_arbiter #(.ADDRESS(16'hFFFE), .BUS_ADDR_DATA_LEN(16), .MIN_GAP(8)) dut_g (
        .clk(clk), .rst(rst),
        .req0(g_req0), .data0(g_data0), .ack0(g_ack0),
        .req1(g_req1), .data1(g_data1), .ack1(g_ack1),
        .bus_req(g_bus_req), .bus_gnt(g_gnt),
        .addr(g_addr), .wr(g_wr), .bus_out(g_bus_out), .busy(g_busy)
    );

    always #5 clk = ~clk;

    // Write logger and gap-instance observer.
    always @(negedge clk) begin
        if (wr)   wq.push_back({addr, bus_out});
        if (g_wr) gq.push_back({g_addr, g_bus_out});
        if (g_ack1) begin
            g_acks++;
            if (g_ack_prev) g_ack_double++;
        end
        g_ack_prev = g_ack1;
        if (g_bus_req) begin
            if (g_seen_hi && g_run > 0 && g_run < g_min_run) g_min_run = g_run;
            g_run = 0;
            g_seen_hi = 1;
        end else if (g_seen_hi) begin
            g_run++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
        check({tag, " wr"}, wr, 1'b1);
        check({tag, " addr"}, addr, a);
        check({tag, " data"}, bus_out, d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        check({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic wait_ack1(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (ack1 !== 1'b1 && n < 30);
        check({tag, " ack1 seen"}, ack1, 1'b1);
    endtask

    // Pops four logged writes and compares with the expected byte sequence.
    task automatic check_burst(input string tag, input logic [15:0] base, input logic [31:0] v, input bit is_g);
        logic [23:0] e, o;
        logic [15:0] a;
        for (int k = 0; k < 4; k++) begin
            a = base + 16'(k);
            e = {a, v[8*k +: 8]};
            if (is_g) o = (gq.size() > 0) ? gq.pop_front() : 24'hxxxxxx;
            else      o = (wq.size() > 0) ? wq.pop_front() : 24'hxxxxxx;
            check($sformatf("%s byte%0d", tag, k), o, e);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req0 = 0; req1 = 0; data0 = 0; data1 = 0; bus_gnt = 0;
        g_req0 = 0; g_req1 = 0; g_data0 = 0; g_data1 = 0; g_gnt = 0;
        step(2);
        check("rst ack0", ack0, 0);
        check("rst ack1", ack1, 0);
        check("rst bus_req", bus_req, 0);
        check("rst wr", wr, 0);
        check("rst addr", addr, 0);
        check("rst bus_out", bus_out, 0);
        check("rst busy", busy, 0);
        check("rst g bus_req", g_bus_req, 0);
        rst = 1'b0;

        // 1: single request, grant tied high
        req0 = 1; data0 = 32'h89ABCDEF; bus_gnt = 1;
        step(1);
        check("t1 ack0", ack0, 1);
        check("t1 ack1", ack1, 0);
        check("t1 busy", busy, 1);
        check("t1 bus_req", bus_req, 1);
        check("t1 wr early", wr, 0);
        req0 = 0;
        step(1);
        check("t1 ack0 pulse", ack0, 0);
        check("t1 grant wr", wr, 0);
        step(1); expect_wr("t1 k0", 16'h0100, 8'hEF);
        step(1); expect_wr("t1 k1", 16'h0101, 8'hCD);
        step(1); expect_wr("t1 k2", 16'h0102, 8'hAB);
        step(1); expect_wr("t1 k3", 16'h0103, 8'h89);
        step(1);
        check("t1 end wr", wr, 0);
        check("t1 end bus_req", bus_req, 0);
        check("t1 end busy", busy, 0);
        wq.delete();

        // 2: contention from reset, then alternation
        rst = 1;
        step(1);
        req0 = 1; req1 = 1; data0 = 32'h11223344; data1 = 32'h55667788;
        rst = 0;
        step(1);
        check("t2 first ack0", ack0, 1);
        check("t2 first ack1", ack1, 0);
        req0 = 0;
        wait_ack1("t2", n);
        check("t2 ack1 latency", n, 7);
        check("t2 ack0 quiet", ack0, 0);
        req1 = 0;
        wait_idle("t2 second");
        check("t2 log size", wq.size(), 8);
        check_burst("t2 req0", 16'h0100, 32'h11223344, 0);
        check_burst("t2 req1", 16'h0100, 32'h55667788, 0);
        req0 = 1; req1 = 1; data0 = 32'h0A0B0C0D; data1 = 32'h01020304;
        step(1);
        check("t2 third ack0", ack0, 1);
        check("t2 third ack1", ack1, 0);
        req0 = 0;
        wait_ack1("t2 third", n);
        req1 = 0;
        wait_idle("t2 third");
        wq.delete();

        // 3: grant withdrawn for three cycles after byte 1
        req0 = 1; data0 = 32'hDEADBEEF; bus_gnt = 1;
        step(1);
        check("t3 ack0", ack0, 1);
        req0 = 0;
        step(2); expect_wr("t3 k0", 16'h0100, 8'hEF);
        step(1); expect_wr("t3 k1", 16'h0101, 8'hBE);
        bus_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("t3 stall%0d wr", i), wr, 0);
        end
        bus_gnt = 1;
        step(1); expect_wr("t3 k2", 16'h0102, 8'hAD);
        step(1); expect_wr("t3 k3", 16'h0103, 8'hDE);
        step(1);
        check("t3 end busy", busy, 0);
        check("t3 wr count", wq.size(), 4);
        check_burst("t3", 16'h0100, 32'hDEADBEEF, 0);
        wq.delete();

        // 6: data changes after ack do not alter the update
        req0 = 1; data0 = 32'hCAFEF00D;
        step(1);
        check("t6 ack0", ack0, 1);
        req0 = 0; data0 = 32'h12345678;
        step(2);
        data0 = 32'h0;
        wait_idle("t6");
        check_burst("t6", 16'h0100, 32'hCAFEF00D, 0);
        wq.delete();

        // 5: reset between bytes 1 and 2, request kept pending
        req0 = 1; data0 = 32'hA5A55A5A;
        step(1);
        check("t5 ack0", ack0, 1);
        step(3); expect_wr("t5 k1", 16'h0101, 8'h5A);
        #2 rst = 1;
        #1;
        check("t5 async bus_req", bus_req, 0);
        check("t5 async wr", wr, 0);
        check("t5 async busy", busy, 0);
        step(1);
        wq.delete();
        rst = 0;
        step(1);
        check("t5 restart ack0", ack0, 1);
        req0 = 0;
        step(2); expect_wr("t5 restart k0", 16'h0100, 8'h5A);
        wait_idle("t5");
        check_burst("t5", 16'h0100, 32'hA5A55A5A, 0);

        // 4: MIN_GAP=8 instance, req1 held, address wraps at 16 bits
        g_req1 = 1; g_data1 = 32'h0BADCAFE; g_gnt = 1;
        step(40);
        check("t4 ack1 count", g_acks, 3);
        check("t4 ack pulse width", g_ack_double, 0);
        check("t4 min bus_req low run", g_min_run, 9);
        check("t4 write count", gq.size(), 12);
        check_burst("t4", 16'hFFFE, 32'h0BADCAFE, 1);
        g_req1 = 0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
